hazard_unit: RTL and testbench

Pipeline hazard unit for the 5-stage MIPS core. It consumes the per-instruction hazard requirements (`DP_Hazards`) that the ID-stage `Control` decoder emits, and tracks the destination registers of the instructions in EX, MEM and WB in its own shadow pipeline. From these it drives the ID stall, the per-stage pipeline freezes and the four operand forwarding selects. It sits beside `Control` in ID; its `ID_Stall` output feeds back into `Control`.

---
 rtl/hazard_unit_pkg.sv | 46 ++++
 rtl/hazard_unit_stage_reg.sv | 39 +++
 rtl/hazard_unit.sv | 120 ++++++++++++
 tb/tb_hazard_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings and shadow-record type for the pipeline hazard unit.
// The HZ_* bit indices are the same ones Control uses to build DP_Hazards.
package hazard_unit_pkg;

    localparam int HAZARD_WIDTH = 4;

    localparam int HZ_RS_ID = 0;
    localparam int HZ_RT_ID = 1;
    localparam int HZ_RS_EX = 2;
    localparam int HZ_RT_EX = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // One in-flight instruction as seen by the hazard unit. The source
    // fields are only kept meaningful in the EX record.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       need_rs_ex;
        logic       need_rt_ex;
    } hz_rec_t;

    function automatic logic rec_writes(input hz_rec_t rec, input logic [4:0] r);
        return rec.valid & rec.reg_write & (rec.dst == r) & (r != 5'd0);
    endfunction

    // MEM beats WB. ID cannot take a load's value from MEM (data not back yet).
    function automatic fwd_sel_e fwd_pick(input hz_rec_t mem_rec, input hz_rec_t wb_rec,
                                          input logic [4:0] r, input logic mem_load_ok);
        if (rec_writes(mem_rec, r) && (mem_load_ok || !mem_rec.mem_read))
            return FWD_MEM;
        else if (rec_writes(wb_rec, r))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_stage_reg.sv
// One shadow pipeline record with async reset and hold / bubble / load control.
// hold beats bubble; a bubble clears every field, not only valid.
module hazard_stage_reg
    import hazard_unit_pkg::*;
#(
    parameter bit HAS_SRC = 1'b0
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    hold,
    input  logic    bubble,
    input  hz_rec_t d,
    output hz_rec_t q
);

    hz_rec_t d_kept;

    always_comb begin
        d_kept = d;
        if (!HAS_SRC) begin
            d_kept.rs         = 5'd0;
            d_kept.rt         = 5'd0;
            d_kept.need_rs_ex = 1'b0;
            d_kept.need_rt_ex = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble)
                q <= '0;
            else
                q <= d_kept;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: shadow EX/MEM/WB destination tracking, ID stall,
// per-stage freezes, operand forward selects and a saturating stall counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [HAZARD_WIDTH-1:0] DP_Hazards,
    input  logic [4:0]              ID_Rs,
    input  logic [4:0]              ID_Rt,
    input  logic [4:0]              ID_RegDst,
    input  logic                    ID_RegWrite,
    input  logic                    ID_MemRead,
    input  logic                    MemBusy,
    output logic                    IF_Stall,
    output logic                    ID_Stall,
    output logic                    EX_Stall,
    output logic                    M_Stall,
    output logic [1:0]              ID_RsFwdSel,
    output logic [1:0]              ID_RtFwdSel,
    output logic [1:0]              EX_RsFwdSel,
    output logic [1:0]              EX_RtFwdSel,
    output logic [STALL_CNT_W-1:0]  StallCount
);

    hz_rec_t id_rec;
    hz_rec_t ex_rec;
    hz_rec_t mem_rec;
    hz_rec_t wb_rec;

    logic need_rs_id;
    logic need_rt_id;
    logic need_rs_ex;
    logic need_rt_ex;
    logic hz_id_ex;
    logic hz_id_mem;
    logic hz_load_use;
    logic hz;

    assign need_rs_id = DP_Hazards[HZ_RS_ID];
    assign need_rt_id = DP_Hazards[HZ_RT_ID];
    assign need_rs_ex = DP_Hazards[HZ_RS_EX];
    assign need_rt_ex = DP_Hazards[HZ_RT_EX];

    always_comb begin
        id_rec            = '0;
        id_rec.valid      = 1'b1;
        id_rec.reg_write  = ID_RegWrite;
        id_rec.mem_read   = ID_MemRead;
        id_rec.dst        = ID_RegDst;
        id_rec.rs         = ID_Rs;
        id_rec.rt         = ID_Rt;
        id_rec.need_rs_ex = need_rs_ex;
        id_rec.need_rt_ex = need_rt_ex;
    end

    hazard_stage_reg #(.HAS_SRC(1'b1)) u_ex_rec (
        .clock  (clock),
        .reset  (reset),
        .hold   (MemBusy),
        .bubble (hz),
        .d      (id_rec),
        .q      (ex_rec)
    );

    hazard_stage_reg #(.HAS_SRC(1'b0)) u_mem_rec (
        .clock  (clock),
        .reset  (reset),
        .hold   (MemBusy),
        .bubble (1'b0),
        .d      (ex_rec),
        .q      (mem_rec)
    );

    hazard_stage_reg #(.HAS_SRC(1'b0)) u_wb_rec (
        .clock  (clock),
        .reset  (reset),
        .hold   (MemBusy),
        .bubble (1'b0),
        .d      (mem_rec),
        .q      (wb_rec)
    );

    // ID consumers (branches) cannot take anything from EX, nor a load from MEM.
    assign hz_id_ex  = (need_rs_id & rec_writes(ex_rec, ID_Rs)) |
                       (need_rt_id & rec_writes(ex_rec, ID_Rt));
    assign hz_id_mem = mem_rec.mem_read &
                       ((need_rs_id & rec_writes(mem_rec, ID_Rs)) |
                        (need_rt_id & rec_writes(mem_rec, ID_Rt)));
    assign hz_load_use = ex_rec.mem_read &
                         ((need_rs_ex & rec_writes(ex_rec, ID_Rs)) |
                          (need_rt_ex & rec_writes(ex_rec, ID_Rt)));
    assign hz = hz_id_ex | hz_id_mem | hz_load_use;

    assign IF_Stall = hz | MemBusy;
    assign ID_Stall = hz | MemBusy;
    assign EX_Stall = MemBusy;
    assign M_Stall  = MemBusy;

    assign ID_RsFwdSel = fwd_pick(mem_rec, wb_rec, ID_Rs, 1'b0);
    assign ID_RtFwdSel = fwd_pick(mem_rec, wb_rec, ID_Rt, 1'b0);
    assign EX_RsFwdSel = fwd_pick(mem_rec, wb_rec, ex_rec.rs, 1'b1);
    assign EX_RtFwdSel = fwd_pick(mem_rec, wb_rec, ex_rec.rt, 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            StallCount <= '0;
        else if (hz && !MemBusy && (StallCount != '1))
            StallCount <= StallCount + STALL_CNT_W'(1);
    end

    // Source and WB load fields exist in every record but only EX/MEM consult them.
    logic unused_rec_bits;
    assign unused_rec_bits = ^{mem_rec.rs, mem_rec.rt, mem_rec.need_rs_ex, mem_rec.need_rt_ex,
                               wb_rec.rs, wb_rec.rt, wb_rec.need_rs_ex, wb_rec.need_rt_ex,
                               wb_rec.mem_read, ex_rec.need_rs_ex, ex_rec.need_rt_ex};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction-level sequences with expected
// stall/forward/counter vectors queued per cycle and compared before each edge.
module tb_hazard_unit;

  localparam int OBS_W = 4 + 8 + 32;

  localparam logic [1:0] F_RF  = 2'b00;
  localparam logic [1:0] F_MEM = 2'b01;
  localparam logic [1:0] F_WB  = 2'b10;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_HZ   = 4'b1100;
  localparam logic [3:0] S_BUSY = 4'b1111;

  localparam logic [3:0] DP_NONE  = 4'b0000;
  localparam logic [3:0] DP_RS_EX = 4'b0100;
  localparam logic [3:0] DP_EX2   = 4'b1100;
  localparam logic [3:0] DP_ID2   = 4'b0011;

  logic        clock;
  logic        reset;
  logic [3:0]  DP_Hazards;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [4:0]  ID_RegDst;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        MemBusy;
  logic        IF_Stall;
  logic        ID_Stall;
  logic        EX_Stall;
  logic        M_Stall;
  logic [1:0]  ID_RsFwdSel;
  logic [1:0]  ID_RtFwdSel;
  logic [1:0]  EX_RsFwdSel;
  logic [1:0]  EX_RtFwdSel;
  logic [31:0] StallCount;

  logic [OBS_W-1:0] exp_q[$];
  string            tag_q[$];
  int               checks;
  int               failures;

  hazard_unit #(.STALL_CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .DP_Hazards  (DP_Hazards),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_RegDst   (ID_RegDst),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .MemBusy     (MemBusy),
    .IF_Stall    (IF_Stall),
    .ID_Stall    (ID_Stall),
    .EX_Stall    (EX_Stall),
    .M_Stall     (M_Stall),
    .ID_RsFwdSel (ID_RsFwdSel),
    .ID_RtFwdSel (ID_RtFwdSel),
    .EX_RsFwdSel (EX_RsFwdSel),
    .EX_RtFwdSel (EX_RtFwdSel),
    .StallCount  (StallCount)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drivers
  task automatic drive(input logic [3:0] dp, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic rw, input logic mr,
                       input logic busy);
    DP_Hazards  = dp;
    ID_Rs       = rs;
    ID_Rt       = rt;
    ID_RegDst   = dst;
    ID_RegWrite = rw;
    ID_MemRead  = mr;
    MemBusy     = busy;
  endtask

  task automatic drive_nop();
    drive(DP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  // Scoreboard: queue the expectation, let inputs settle, then compare.
  task automatic check_step(input string tag, input logic [3:0] stalls,
                            input logic [1:0] id_rs, input logic [1:0] id_rt,
                            input logic [1:0] ex_rs, input logic [1:0] ex_rt,
                            input logic [31:0] cnt);
    logic [OBS_W-1:0] observed;
    logic [OBS_W-1:0] expected;
    string            t;
    exp_q.push_back({stalls, id_rs, id_rt, ex_rs, ex_rt, cnt});
    tag_q.push_back(tag);
    #1;
    observed = {IF_Stall, ID_Stall, EX_Stall, M_Stall,
                ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel, StallCount};
    expected = exp_q.pop_front();
    t        = tag_q.pop_front();
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, observed, expected);
    end
  endtask

  // Per-cycle stall-consistency monitor
  always @(negedge clock) begin
    #2;
    checks++;
    if (IF_Stall !== ID_Stall) begin
      failures++;
      $error("FAIL if_id_stall observed=%b expected=%b", IF_Stall, ID_Stall);
    end
    checks++;
    if ((EX_Stall !== MemBusy) || (M_Stall !== MemBusy)) begin
      failures++;
      $error("FAIL ex_m_stall observed=%b%b expected=%b%b", EX_Stall, M_Stall, MemBusy, MemBusy);
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_nop();
    check_step("reset", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$3
    drive(DP_EX2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    check_step("alu_add_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();
    drive(DP_EX2, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    check_step("alu_sub_no_stall", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();
    drive_nop();
    check_step("alu_ex_fwd_mem", S_NONE, F_RF, F_RF, F_MEM, F_MEM, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      check_step("alu_flush", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
      next_cycle();
    end

    // lw $8,0($9) ; add $10,$8,$0
    drive(DP_RS_EX, 5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    check_step("lu_lw_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();
    drive(DP_EX2, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    check_step("lu_stall", S_HZ, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();
    check_step("lu_released", S_NONE, F_RF, F_RF, F_RF, F_RF, 1);
    next_cycle();
    drive_nop();
    check_step("lu_ex_fwd_wb", S_NONE, F_RF, F_RF, F_WB, F_RF, 1);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      check_step("lu_flush", S_NONE, F_RF, F_RF, F_RF, F_RF, 1);
      next_cycle();
    end

    // lw $2,0($3) ; beq $2,$0
    drive(DP_RS_EX, 5'd3, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    check_step("bl_lw_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 1);
    next_cycle();
    drive(DP_ID2, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check_step("bl_stall_ex", S_HZ, F_RF, F_RF, F_RF, F_RF, 1);
    next_cycle();
    check_step("bl_stall_mem", S_HZ, F_RF, F_RF, F_RF, F_RF, 2);
    next_cycle();
    check_step("bl_id_fwd_wb", S_NONE, F_WB, F_RF, F_RF, F_RF, 3);
    next_cycle();
    drive_nop();
    for (int i = 0; i < 2; i++) begin
      check_step("bl_flush", S_NONE, F_RF, F_RF, F_RF, F_RF, 3);
      next_cycle();
    end

    // addi $0,$0,1 ; beq $0,$0 (x3)
    drive(DP_RS_EX, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check_step("r0_addi_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 3);
    next_cycle();
    drive(DP_ID2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_step("r0_beq_no_hazard", S_NONE, F_RF, F_RF, F_RF, F_RF, 3);
      next_cycle();
    end
    drive_nop();
    for (int i = 0; i < 2; i++) begin
      check_step("r0_flush", S_NONE, F_RF, F_RF, F_RF, F_RF, 3);
      next_cycle();
    end

    // add $5,$6,$7 ; beq $5,$0
    drive(DP_EX2, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0);
    check_step("ba_add_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 3);
    next_cycle();
    drive(DP_ID2, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check_step("ba_stall", S_HZ, F_RF, F_RF, F_RF, F_RF, 3);
    next_cycle();
    check_step("ba_id_fwd_mem", S_NONE, F_MEM, F_RF, F_RF, F_RF, 4);
    next_cycle();
    drive_nop();
    check_step("ba_ex_fwd_wb", S_NONE, F_RF, F_RF, F_WB, F_RF, 4);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      check_step("ba_flush", S_NONE, F_RF, F_RF, F_RF, F_RF, 4);
      next_cycle();
    end

    // lw $8,0($9) ; add $10,$8,$0 with MemBusy held for 3 cycles
    drive(DP_RS_EX, 5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    check_step("mb_lw_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 4);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(DP_EX2, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1);
      check_step("mb_frozen", S_BUSY, F_RF, F_RF, F_RF, F_RF, 4);
      next_cycle();
    end
    drive(DP_EX2, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    check_step("mb_hz_after_release", S_HZ, F_RF, F_RF, F_RF, F_RF, 4);
    next_cycle();
    check_step("mb_proceed", S_NONE, F_RF, F_RF, F_RF, F_RF, 5);
    next_cycle();
    drive_nop();
    check_step("mb_ex_fwd_wb", S_NONE, F_RF, F_RF, F_WB, F_RF, 5);
    next_cycle();

    // lw $5 in EX, ID needs $5 in EX, then reset mid-stall
    drive(DP_RS_EX, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    check_step("rs_lw_issue", S_NONE, F_RF, F_RF, F_RF, F_RF, 5);
    next_cycle();
    drive(DP_EX2, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    check_step("rs_stall", S_HZ, F_RF, F_RF, F_RF, F_RF, 5);
    reset = 1'b1;
    check_step("rs_reset_immediate", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();
    reset = 1'b0;
    check_step("rs_after_reset", S_NONE, F_RF, F_RF, F_RF, F_RF, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
